// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_e   : sequencer state encoding
//   RST_COUNT_W   : width of the reset-event counter
//   RST_COUNT_SAT : value at which the reset-event counter saturates
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } seq_state_e;

  localparam int unsigned RST_COUNT_W = 8;
  localparam logic [RST_COUNT_W-1:0] RST_COUNT_SAT = '1;

endpackage

// File: rtl/btn_debouncer.sv
// Push-button debouncer. The output level follows the already-synchronized
// button only after the input has held a new value for DEBOUNCE_CYCLES
// consecutive cycles; any bounce restarts the count.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   btn_sync_n     : synchronized button level (pressed = 0)
//   level_n        : debounced level (pressed = 0), resets to released
//   press          : one-cycle pulse on a debounced 1->0 change
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic btn_sync_n,
  output logic level_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      level_n <= 1'b1;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_sync_n == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt     <= '0;
        level_n <= btn_sync_n;
        press   <= ~btn_sync_n;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Central reset controller. Stretches any reset event to a minimum width,
// waits for PLL lock, then releases NUM_DOMAINS active-low resets one at a
// time, STAGE_DELAY cycles apart, lowest index first. All outputs fall
// together on any trigger (software request, button, lock loss while
// releasing/running).
// Build option: define RST_SEQ_DEBOUNCE_EN to debounce the button;
// otherwise the synchronized button level is used directly.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_btn_n        : raw push-button, pressed = 0
//   i_pll_locked   : raw PLL lock level
//   i_sw_rst       : single-cycle synchronous reset request
//   o_rst_n        : per-domain registered resets, active-low
//   o_busy         : high while any o_rst_n bit is low
//   o_rst_count    : saturating count of reset events since i_rst_n
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS     = 3,
  parameter int unsigned STRETCH_CYCLES  = 16,
  parameter int unsigned STAGE_DELAY     = 256,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_btn_n,
  input  logic                   i_pll_locked,
  input  logic                   i_sw_rst,
  output logic [NUM_DOMAINS-1:0] o_rst_n,
  output logic                   o_busy,
  output logic [RST_COUNT_W-1:0] o_rst_count
);

  localparam int unsigned STRETCH_W = $clog2(STRETCH_CYCLES);
  localparam int unsigned STAGE_W   = $clog2(STAGE_DELAY);
  localparam int unsigned DOM_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [STRETCH_W-1:0] STRETCH_MAX = STRETCH_W'(STRETCH_CYCLES - 1);
  localparam logic [STAGE_W-1:0]   STAGE_MAX   = STAGE_W'(STAGE_DELAY - 1);
  localparam logic [DOM_W-1:0]     DOM_LAST    = DOM_W'(NUM_DOMAINS - 1);

  // Input synchronizers
  logic btn_meta, btn_sync;
  logic lock_meta, lock_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta  <= 1'b1;
      btn_sync  <= 1'b1;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      btn_meta  <= i_btn_n;
      btn_sync  <= btn_meta;
      lock_meta <= i_pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // Button trigger
  logic btn_trig;

`ifdef RST_SEQ_DEBOUNCE_EN
  logic deb_level_n;
  logic deb_press;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .btn_sync_n (btn_sync),
    .level_n    (deb_level_n),
    .press      (deb_press)
  );

  assign btn_trig = deb_press | ~deb_level_n;
`else
  // DEBOUNCE_CYCLES has no effect in this build; tie it off so it is referenced.
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);

  // Without debouncing a press event always coincides with the held level.
  assign btn_trig = ~btn_sync;
`endif

  // Sequencer state
  seq_state_e             state, state_d;
  logic [STRETCH_W-1:0]   stretch_cnt, stretch_d;
  logic [STAGE_W-1:0]     stage_cnt, stage_d;
  logic [DOM_W-1:0]       dom_idx, dom_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic [RST_COUNT_W-1:0] count_q, count_d;
  logic                   trigger;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_HOLD;
      stretch_cnt <= '0;
      stage_cnt   <= '0;
      dom_idx     <= '0;
      rst_q       <= '0;
      count_q     <= '0;
    end else begin
      state       <= state_d;
      stretch_cnt <= stretch_d;
      stage_cnt   <= stage_d;
      dom_idx     <= dom_d;
      rst_q       <= rst_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d   = state;
    stretch_d = stretch_cnt;
    stage_d   = stage_cnt;
    dom_d     = dom_idx;
    rst_d     = rst_q;
    count_d   = count_q;

    // Lock loss only counts once releasing has begun.
    trigger = i_sw_rst | btn_trig |
              (~lock_sync & ((state == S_RELEASE) | (state == S_RUN)));

    case (state)
      S_HOLD: begin
        rst_d = '0;
        if (trigger) begin
          stretch_d = '0;
        end else if (stretch_cnt == STRETCH_MAX) begin
          stretch_d = '0;
          state_d   = S_WAIT_LOCK;
        end else begin
          stretch_d = stretch_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_sync) begin
          state_d = S_RELEASE;
          stage_d = '0;
          dom_d   = '0;
        end
      end
      S_RELEASE: begin
        if (stage_cnt == STAGE_MAX) begin
          stage_d        = '0;
          rst_d[dom_idx] = 1'b1;
          dom_d          = dom_idx + 1'b1;
          if (dom_idx == DOM_LAST) begin
            state_d = S_RUN;
          end
        end else begin
          stage_d = stage_cnt + 1'b1;
        end
      end
      S_RUN: begin
        rst_d = '1;
      end
      default: begin
        state_d = S_HOLD;
        rst_d   = '0;
      end
    endcase

    // Any trigger outside S_HOLD overrides the per-state decisions above.
    if (trigger && (state != S_HOLD)) begin
      state_d   = S_HOLD;
      stretch_d = '0;
      rst_d     = '0;
      if (count_q != RST_COUNT_SAT) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign o_rst_n     = rst_q;
  assign o_busy      = ~(&rst_q);
  assign o_rst_count = count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

  localparam int ND  = 3;
  localparam int STR = 4;
  localparam int SD  = 8;
  localparam int DEB = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          btn_n = 1'b1;
  logic          pll   = 1'b1;
  logic          sw    = 1'b0;
  logic [ND-1:0] rst_out;
  logic          busy;
  logic [7:0]    rcount;

  rst_sequencer #(
    .NUM_DOMAINS     (ND),
    .STRETCH_CYCLES  (STR),
    .STAGE_DELAY     (SD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_btn_n      (btn_n),
    .i_pll_locked (pll),
    .i_sw_rst     (sw),
    .o_rst_n      (rst_out),
    .o_busy       (busy),
    .o_rst_count  (rcount)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: event timestamps relative to the last i_rst_n release.
  int            e;          // index of the last rising edge
  int            wait_edge;  // edge at which the stretch period ends
  int            rs;         // edge at which releasing started
  bit            rs_valid;
  int            m_count;
  bit            lock_q[$];
  bit            btn_q[$];
  bit            deb_lvl;
  int            deb_run;
  logic [ND-1:0] exp_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_init();
    e         = 0;
    wait_edge = STR;
    rs        = 0;
    rs_valid  = 1'b0;
    m_count   = 0;
    lock_q.delete();
    btn_q.delete();
    deb_lvl   = 1'b1;
    deb_run   = 0;
    exp_rst   = '0;
  endfunction

  function automatic void model_edge();
    bit lk, bt, btrig, trig;
    e++;
    lock_q.push_back(pll);
    btn_q.push_back(btn_n);
    // Inputs reach the control logic two edges after being sampled.
    lk = (e >= 3) ? lock_q[e-3] : 1'b0;
    bt = (e >= 3) ? btn_q[e-3] : 1'b1;
`ifdef RST_SEQ_DEBOUNCE_EN
    btrig = !deb_lvl;
    if (bt != deb_lvl) begin
      deb_run++;
      if (deb_run == DEB) begin
        deb_lvl = bt;
        deb_run = 0;
      end
    end else begin
      deb_run = 0;
    end
`else
    btrig = !bt;
`endif
    trig = sw || btrig || (rs_valid && (e > rs) && !lk);
    if (trig) begin
      if (e > wait_edge && m_count < 255) m_count++;
      wait_edge = e + STR;
      rs_valid  = 1'b0;
    end else if (!rs_valid && e > wait_edge && lk) begin
      rs       = e;
      rs_valid = 1'b1;
    end
    for (int k = 0; k < ND; k++)
      exp_rst[k] = rs_valid && (e >= rs + (k + 1) * SD);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rst_n", 32'(rst_out), 32'(exp_rst));
    chk("busy", 32'(busy), 32'(exp_rst != '1));
    chk("count", 32'(rcount), 32'(m_count));
  endtask

  task automatic do_reset(input logic lock_val);
    @(negedge clk);
    rst_n = 1'b0;
    pll   = lock_val;
    btn_n = 1'b1;
    sw    = 1'b0;
    #1;
    chk("reset_rst_n", 32'(rst_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_count", 32'(rcount), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  int t0, t1, m_before;

  initial begin
    // Power-up with lock already high
    do_reset(1'b1);
    while (e < 35) begin
      tick();
      if (e == 12) chk("pwr_e12", 32'(rst_out), 32'b000);
      if (e == 13) chk("pwr_e13", 32'(rst_out), 32'b001);
      if (e == 21) chk("pwr_e21", 32'(rst_out), 32'b011);
      if (e == 28) chk("pwr_busy_e28", 32'(busy), 32'd1);
      if (e == 29) begin
        chk("pwr_e29", 32'(rst_out), 32'b111);
        chk("pwr_busy_e29", 32'(busy), 32'd0);
        chk("pwr_count", 32'(rcount), 32'd0);
      end
    end

    // Late lock: lock rises after edge 40
    do_reset(1'b0);
    while (e < 40) tick();
    pll = 1'b1;
    while (e < 52) begin
      tick();
      if (e == 50) chk("late_e50", 32'(rst_out), 32'b000);
      if (e == 51) chk("late_e51", 32'(rst_out), 32'b001);
    end

    // Software reset coincident with a lock drop, from S_RUN
    while (e < 80) tick();
    sw  = 1'b1;
    pll = 1'b0;
    tick();
    chk("sw_assert", 32'(rst_out), 32'b000);
    chk("sw_count_once", 32'(rcount), 32'd1);
    t0  = e;
    sw  = 1'b0;
    pll = 1'b1;
    while (e < t0 + 13) begin
      tick();
      if (e == t0 + 12) chk("sw_rel_pre", 32'(rst_out), 32'b000);
      if (e == t0 + 13) chk("sw_rel_d0", 32'(rst_out), 32'b001);
    end

    // Trigger in the middle of releasing
    sw = 1'b1;
    tick();
    chk("mid_clear", 32'(rst_out), 32'b000);
    t1 = e;
    sw = 1'b0;
    while (e < t1 + 13) begin
      tick();
      if (e == t1 + 12) chk("mid_rel_pre", 32'(rst_out), 32'b000);
      if (e == t1 + 13) chk("mid_rel_d0", 32'(rst_out), 32'b001);
    end
    repeat (40) tick();

    // Button: short glitches, then a long press
    m_before = m_count;
    repeat (3) begin
      btn_n = 1'b0;
      repeat (10) tick();
      btn_n = 1'b1;
      repeat (30) tick();
    end
`ifdef RST_SEQ_DEBOUNCE_EN
    chk("glitch_count", 32'(rcount), 32'(m_before));
`else
    chk("glitch_count", 32'(rcount), 32'(m_before + 3));
`endif
    btn_n = 1'b0;
    repeat (100) tick();
    chk("btn_held", 32'(rst_out), 32'b000);
    btn_n = 1'b1;
    repeat (80) tick();

    // Randomized traffic on all trigger sources
    for (int i = 0; i < 4000; i++) begin
      sw = ($urandom_range(0, 199) == 0);
      if (pll && $urandom_range(0, 399) == 0) pll = 1'b0;
      else if (!pll && $urandom_range(0, 19) == 0) pll = 1'b1;
      if (btn_n && $urandom_range(0, 499) == 0) btn_n = 1'b0;
      else if (!btn_n && $urandom_range(0, 14) == 0) btn_n = 1'b1;
      tick();
    end
    sw    = 1'b0;
    pll   = 1'b1;
    btn_n = 1'b1;
    repeat (60) tick();

    // Counter saturation
    repeat (300) begin
      sw = 1'b1;
      tick();
      sw = 1'b0;
      repeat (7) tick();
    end
    chk("sat_count", 32'(rcount), 32'd255);

    // Asynchronous reset between clock edges while running
    repeat (40) tick();
    chk("async_pre_run", 32'(rst_out), 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_n", 32'(rst_out), 32'b000);
    chk("async_busy", 32'(busy), 32'd1);
    chk("async_count", 32'(rcount), 32'd0);
    #20;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
